// File: rtl/comet_ii_boot_ctrl_pkg.sv
// comet_ii_pkg: shared boot-sequencer state encoding, error codes and frame constants
package comet_ii_pkg;

    typedef enum logic [3:0] {
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_HDR3,
        S_HDR4,
        S_LOAD,
        S_CSUM,
        S_START,
        S_RUN,
        S_ERR
    } boot_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MAGIC   = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [15:0] MAGIC_DEF = 16'hC2C2;

endpackage

// File: rtl/comet_ii_boot_ctrl_if.sv
// comet_ii_boot_ctrl_if: 16-bit valid/ready loader stream from the host link
interface comet_ii_boot_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/comet_ii_wport_mux.sv
// comet_ii_wport_mux: selects loader or core as the source of the memory write port
module comet_ii_wport_mux (
    input  logic        core_sel_i,
    input  logic        ld_we_i,
    input  logic [15:0] ld_waddr_i,
    input  logic [15:0] ld_wdata_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_waddr_i,
    input  logic [15:0] cpu_wdata_i,
    output logic        mem_we_o,
    output logic [15:0] mem_waddr_o,
    output logic [15:0] mem_wdata_o
);

    assign mem_we_o    = core_sel_i ? cpu_we_i    : ld_we_i;
    assign mem_waddr_o = core_sel_i ? cpu_waddr_i : ld_waddr_i;
    assign mem_wdata_o = core_sel_i ? cpu_wdata_i : ld_wdata_i;

endmodule

// File: rtl/comet_ii_boot_ctrl.sv
// comet_ii_boot_ctrl: receives a framed program image, loads memory, checks it and releases the core
module comet_ii_boot_ctrl
    import comet_ii_pkg::*;
#(
    parameter logic [15:0] MAGIC       = MAGIC_DEF,
    parameter int          TIMEOUT_CYC = 1024,
    parameter int          TO_W        = 11
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 boot_req,
    comet_ii_boot_ctrl_if.slave  sif,
    output logic                 cpu_rst,
    output logic                 cpu_init,
    output logic [15:0]          PR_init,
    output logic [15:0]          SP_init,
    input  logic                 cpu_we,
    input  logic [15:0]          cpu_waddr,
    input  logic [15:0]          cpu_wdata,
    output logic                 mem_we,
    output logic [15:0]          mem_waddr,
    output logic [15:0]          mem_wdata,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           err_code
);

    boot_state_e     state_q, state_d;
    logic [15:0]     load_addr_q, load_addr_d;
    logic [15:0]     n_q, n_d;
    logic [15:0]     idx_q, idx_d;
    logic [15:0]     sum_q, sum_d;
    logic [15:0]     pr_q, pr_d;
    logic [15:0]     sp_q, sp_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [1:0]      code_q, code_d;

    logic timed, to_hit, acc, run_sel;

    // timeout only watches the gaps inside a started frame; a hit blocks further acceptance
    assign timed    = state_q inside {S_HDR1, S_HDR2, S_HDR3, S_HDR4, S_LOAD, S_CSUM};
    assign to_hit   = timed && (to_q == TO_W'(TIMEOUT_CYC));
    assign acc      = sif.in_valid && sif.in_ready;
    assign run_sel  = rst && !boot_req && (state_q == S_RUN);

    assign sif.in_ready = rst && !boot_req && !to_hit && (state_q <= S_CSUM);
    assign cpu_rst      = !rst || !(state_q inside {S_START, S_RUN});
    assign cpu_init     = rst && (state_q == S_START);
    assign busy         = !rst || !(state_q inside {S_RUN, S_ERR});
    assign err          = rst && (state_q == S_ERR);
    assign err_code     = err ? code_q : ERR_NONE;
    assign PR_init      = rst ? pr_q : 16'h0000;
    assign SP_init      = rst ? sp_q : 16'h0000;

    comet_ii_wport_mux u_wport_mux (
        .core_sel_i  (run_sel),
        .ld_we_i     (acc && (state_q == S_LOAD)),
        .ld_waddr_i  (load_addr_q + idx_q),
        .ld_wdata_i  (sif.in_data),
        .cpu_we_i    (cpu_we),
        .cpu_waddr_i (cpu_waddr),
        .cpu_wdata_i (cpu_wdata),
        .mem_we_o    (mem_we),
        .mem_waddr_o (mem_waddr),
        .mem_wdata_o (mem_wdata)
    );

    // frame parser: header capture, load/checksum accumulation, timeout and restart
    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        n_d         = n_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        pr_d        = pr_q;
        sp_d        = sp_q;
        code_d      = code_q;
        to_d        = timed ? (acc ? '0 : to_q + TO_W'(1)) : '0;
        unique case (state_q)
            S_HDR0: begin
                idx_d = '0;
                sum_d = '0;
                if (acc) begin
                    state_d = (sif.in_data == MAGIC) ? S_HDR1 : S_ERR;
                    code_d  = (sif.in_data == MAGIC) ? ERR_NONE : ERR_MAGIC;
                end
            end
            S_HDR1: if (acc) begin
                load_addr_d = sif.in_data;
                state_d     = S_HDR2;
            end
            S_HDR2: if (acc) begin
                n_d     = sif.in_data;
                state_d = S_HDR3;
            end
            S_HDR3: if (acc) begin
                pr_d    = sif.in_data;
                state_d = S_HDR4;
            end
            S_HDR4: if (acc) begin
                sp_d    = sif.in_data;
                state_d = (n_q == 16'h0000) ? S_CSUM : S_LOAD;
            end
            S_LOAD: if (acc) begin
                sum_d   = sum_q ^ sif.in_data;
                idx_d   = idx_q + 16'd1;
                state_d = (idx_q == n_q - 16'd1) ? S_CSUM : S_LOAD;
            end
            S_CSUM: if (acc) begin
                state_d = (sif.in_data == sum_q) ? S_START : S_ERR;
                code_d  = (sif.in_data == sum_q) ? ERR_NONE : ERR_CSUM;
            end
            S_START: state_d = S_RUN;
            default: state_d = state_q;
        endcase
        if (to_hit) begin
            state_d = S_ERR;
            code_d  = ERR_TIMEOUT;
        end
        if (boot_req) begin
            state_d = S_HDR0;
            to_d    = '0;
            idx_d   = '0;
            sum_d   = '0;
            code_d  = ERR_NONE;
        end
    end

    // state and datapath registers, cleared by the active-low synchronous reset
    always_ff @(posedge mclk) begin
        if (!rst) begin
            state_q     <= S_HDR0;
            load_addr_q <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            pr_q        <= '0;
            sp_q        <= '0;
            to_q        <= '0;
            code_q      <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            pr_q        <= pr_d;
            sp_q        <= sp_d;
            to_q        <= to_d;
            code_q      <= code_d;
        end
    end

endmodule

// File: tb/tb_comet_ii_boot_ctrl.sv
// tb_comet_ii_boot_ctrl: directed-vector bench for the boot/load sequencer
module tb_comet_ii_boot_ctrl;

    logic        mclk = 1'b0;
    logic        rst;
    logic        boot_req;
    logic        cpu_rst, cpu_init;
    logic [15:0] PR_init, SP_init;
    logic        cpu_we;
    logic [15:0] cpu_waddr, cpu_wdata;
    logic        mem_we;
    logic [15:0] mem_waddr, mem_wdata;
    logic        busy, err;
    logic [1:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int init_cnt = 0;
    logic [31:0] wlog[$];

    comet_ii_boot_ctrl_if sif ();

    comet_ii_boot_ctrl dut (
        .mclk      (mclk),
        .rst       (rst),
        .boot_req  (boot_req),
        .sif       (sif),
        .cpu_rst   (cpu_rst),
        .cpu_init  (cpu_init),
        .PR_init   (PR_init),
        .SP_init   (SP_init),
        .cpu_we    (cpu_we),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (mem_we) wlog.push_back({mem_waddr, mem_wdata});
        if (cpu_init) init_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        sif.in_valid = 1'b1;
        sif.in_data  = w;
        @(negedge mclk);
        check("accept", sif.in_ready, 1);
        step();
        sif.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f[$]);
        foreach (f[i]) send(f[i]);
    endtask

    task automatic restart();
        boot_req = 1'b1;
        step();
        boot_req = 1'b0;
        wlog.delete();
        init_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; boot_req = 1'b0; cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
        sif.in_valid = 1'b0; sif.in_data = '0;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        check("rst_ready", sif.in_ready, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_init", cpu_init, 0);
        check("rst_busy", busy, 1);
        check("rst_err", {err, err_code}, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_pr_sp", {PR_init, SP_init}, 0);
        step();
        rst = 1'b1;
        @(negedge mclk);
        check("hdr0_ready", sif.in_ready, 1);
        step();
        wlog.delete();
        init_cnt = 0;

        // normal boot
        send_frame('{16'hC2C2, 16'h0100, 16'h0003, 16'h0100, 16'h00F0, 16'h1111, 16'h2222, 16'h4444, 16'h7777});
        @(negedge mclk);
        check("start_init", cpu_init, 1);
        check("start_cpu_rst", cpu_rst, 0);
        check("start_ready", sif.in_ready, 0);
        check("start_pr", PR_init, 16'h0100);
        check("start_sp", SP_init, 16'h00F0);
        check("nb_wcnt", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("nb_w0", wlog[0], 32'h0100_1111);
            check("nb_w1", wlog[1], 32'h0101_2222);
            check("nb_w2", wlog[2], 32'h0102_4444);
        end
        step();
        @(negedge mclk);
        check("run_busy", busy, 0);
        check("run_init", cpu_init, 0);
        check("run_cpu_rst", cpu_rst, 0);
        cpu_we = 1'b1; cpu_waddr = 16'h0200; cpu_wdata = 16'hABCD;
        #1;
        check("run_pass", {mem_we, mem_waddr, mem_wdata}, {1'b1, 16'h0200, 16'hABCD});
        cpu_we = 1'b0;
        step();

        // bad magic, then restart
        restart();
        @(negedge mclk);
        check("hdr0_keep_pr", PR_init, 16'h0100);
        cpu_we = 1'b1;
        #1;
        check("hdr0_core_ignored", mem_we, 0);
        cpu_we = 1'b0;
        step();
        send(16'h1234);
        @(negedge mclk);
        check("magic_err", {err, err_code}, 3'b101);
        check("magic_ready", sif.in_ready, 0);
        check("magic_cpu_rst", cpu_rst, 1);
        check("magic_busy", busy, 0);
        restart();
        @(negedge mclk);
        check("restart_code", {err, err_code}, 0);
        check("restart_busy", busy, 1);
        step();

        // checksum failure
        send_frame('{16'hC2C2, 16'h0100, 16'h0003, 16'h0100, 16'h00F0, 16'h1111, 16'h2222, 16'h4444, 16'h0000});
        @(negedge mclk);
        check("csum_err", {err, err_code}, 3'b110);
        check("csum_wcnt", wlog.size(), 3);
        check("csum_no_init", init_cnt, 0);
        restart();

        // zero length
        send_frame('{16'hC2C2, 16'h0300, 16'h0000, 16'h0010, 16'h0020, 16'h0000});
        @(negedge mclk);
        check("zero_init", cpu_init, 1);
        check("zero_wcnt", wlog.size(), 0);
        step();
        restart();

        // address wrap
        send_frame('{16'hC2C2, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'hAAAA, 16'h5555, 16'hFFFF});
        @(negedge mclk);
        check("wrap_init", cpu_init, 1);
        check("wrap_wcnt", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("wrap_w0", wlog[0], 32'hFFFF_AAAA);
            check("wrap_w1", wlog[1], 32'h0000_5555);
        end
        step();
        restart();

        // timeout after third data word
        send_frame('{16'hC2C2, 16'h0400, 16'h0005, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0003});
        repeat (1000) step();
        @(negedge mclk);
        check("to_not_yet", err, 0);
        for (int i = 0; i < 100 && !err; i++) step();
        @(negedge mclk);
        check("to_err", {err, err_code}, 3'b111);
        restart();

        // boot_req during LOAD with a word presented
        send_frame('{16'hC2C2, 16'h0500, 16'h0004, 16'h0000, 16'h0000, 16'h0001});
        sif.in_valid = 1'b1; sif.in_data = 16'h9999; boot_req = 1'b1;
        @(negedge mclk);
        check("br_ready", sif.in_ready, 0);
        check("br_mem_we", mem_we, 0);
        step();
        boot_req = 1'b0; sif.in_valid = 1'b0;
        @(negedge mclk);
        check("br_hdr0", {sif.in_ready, busy, cpu_rst}, 3'b111);
        check("br_wcnt", wlog.size(), 1);
        step();
        send(16'h1234);
        @(negedge mclk);
        check("br_in_hdr0", {err, err_code}, 3'b101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
